// File: rtl/regfile_pkg.sv
// Shared constants and configuration helpers for the multi-port register file.
package regfile_pkg;
  localparam int RF_DATA_W    = 19;
  localparam int RF_NUM_REGS  = 8;
  localparam int RF_ADDR_W    = 3;
  localparam int RF_ZERO_ADDR = 0;

  function automatic int rf_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Depth must be an exact power of two so every address maps to a register.
  function automatic bit rf_cfg_ok(input int num_regs, input int addr_w, input int num_wr);
    return (num_regs >= 2) && ((1 << addr_w) == num_regs) &&
           (addr_w == rf_clog2(num_regs)) && (num_wr >= 1) && (num_wr <= 4);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: reservation sets, flush/writeback clear, busy lookup.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic                flush,
  input  logic [NUM_REGS-1:0] wr_hit,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic                rs1_busy,
  output logic                rs2_busy
);
  logic [NUM_REGS-1:0] pending, pending_nxt, busy_mask;

  // A fresh reservation beats a same-cycle writeback or flush of that register.
  always_comb begin
    pending_nxt = flush ? '0 : (pending & ~wr_hit);
    if (rsv_en) pending_nxt[rsv_addr] = 1'b1;
    pending_nxt[RF_ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  // With forwarding, an in-flight write satisfies the consumer this cycle.
  assign busy_mask = (BYPASS != 0) ? ~wr_hit : '1;
  assign rs1_busy  = pending[rs1_addr] & busy_mask[rs1_addr];
  assign rs2_busy  = pending[rs2_addr] & busy_mask[rs2_addr];
endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised register file: N prioritised write ports, optional bypass, pending scoreboard.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        rs1_addr,
  input  logic [ADDR_W-1:0]        rs2_addr,
  output logic [DATA_W-1:0]        rs1_data,
  output logic [DATA_W-1:0]        rs2_data,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush
);
  if (!rf_cfg_ok(NUM_REGS, ADDR_W, NUM_WR)) begin : g_bad_cfg
    $error("regfile_mp_sb: illegal NUM_REGS/ADDR_W/NUM_WR combination");
  end

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0][DATA_W-1:0] wr_val;
  logic [NUM_REGS-1:0]             wr_hit;
  logic [DATA_W-1:0]               rs1_raw, rs2_raw;

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_comb begin
    wr_hit = '0;
    wr_val = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k]) begin
        wr_hit[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b1;
        wr_val[wr_addr[k*ADDR_W +: ADDR_W]] = wr_data[k*DATA_W +: DATA_W];
      end
    end
    wr_hit[RF_ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++)
        if (wr_hit[r]) regs[r] <= wr_val[r];
    end
  end

  always_comb begin
    rs1_raw = regs[rs1_addr];
    rs2_raw = regs[rs2_addr];
    if (BYPASS != 0 && wr_hit[rs1_addr]) rs1_raw = wr_val[rs1_addr];
    if (BYPASS != 0 && wr_hit[rs2_addr]) rs2_raw = wr_val[rs2_addr];
  end

  // Bypass data would leak through during reset without this gate.
  assign rs1_data = rst_n ? rs1_raw : '0;
  assign rs2_data = rst_n ? rs2_raw : '0;

  regfile_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .BYPASS  (BYPASS)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .flush   (flush),
    .wr_hit  (wr_hit),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy)
  );
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench: default config with and without bypass sharing stimulus, plus a wide 3-port config.
module tb_regfile_mp_sb;
  localparam int DW = 19, NR = 8, AW = 3, NW = 2;
  localparam int BDW = 32, BNR = 16, BAW = 4, BNW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    rs1_addr, rs2_addr, rsv_addr;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             rsv_en, flush;
  logic [DW-1:0]    d_rs1_data, d_rs2_data, n_rs1_data, n_rs2_data;
  logic             d_rs1_busy, d_rs2_busy, n_rs1_busy, n_rs2_busy;

  logic [BAW-1:0]     b_rs1_addr, b_rs2_addr, b_rsv_addr;
  logic [BNW-1:0]     b_wr_en;
  logic [BNW*BAW-1:0] b_wr_addr;
  logic [BNW*BDW-1:0] b_wr_data;
  logic               b_rsv_en, b_flush;
  logic [BDW-1:0]     b_rs1_data, b_rs2_data;
  logic               b_rs1_busy, b_rs2_busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0]  m_reg [NR];
  bit             m_pend[NR];
  logic [BDW-1:0] bm_reg [BNR];
  bit             bm_pend[BNR];

  regfile_mp_sb #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_WR(NW), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(d_rs1_data), .rs2_data(d_rs2_data), .rs1_busy(d_rs1_busy), .rs2_busy(d_rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush));

  regfile_mp_sb #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_WR(NW), .BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(n_rs1_data), .rs2_data(n_rs2_data), .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush));

  regfile_mp_sb #(.DATA_W(BDW), .NUM_REGS(BNR), .ADDR_W(BAW), .NUM_WR(BNW), .BYPASS(1)) u_big (
    .clk(clk), .rst_n(rst_n), .rs1_addr(b_rs1_addr), .rs2_addr(b_rs2_addr),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data), .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .flush(b_flush));

  // ---------------- reference model ----------------
  function automatic bit s_wr_hit(input int a);
    bit hit = 0;
    for (int k = 0; k < NW; k++) if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) hit = 1;
    return (a != 0) && hit;
  endfunction

  function automatic logic [DW-1:0] s_exp_data(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp) for (int k = NW-1; k >= 0; k--)
      if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) return wr_data[k*DW +: DW];
    return m_reg[a];
  endfunction

  function automatic bit s_exp_busy(input int a, input bit byp);
    return (a != 0) && m_pend[a] && !(byp && s_wr_hit(a));
  endfunction

  function automatic bit b_wr_hit(input int a);
    bit hit = 0;
    for (int k = 0; k < BNW; k++) if (b_wr_en[k] && int'(b_wr_addr[k*BAW +: BAW]) == a) hit = 1;
    return (a != 0) && hit;
  endfunction

  function automatic logic [BDW-1:0] b_exp_data(input int a);
    if (a == 0) return '0;
    for (int k = BNW-1; k >= 0; k--)
      if (b_wr_en[k] && int'(b_wr_addr[k*BAW +: BAW]) == a) return b_wr_data[k*BDW +: BDW];
    return bm_reg[a];
  endfunction

  function automatic bit b_exp_busy(input int a);
    return (a != 0) && bm_pend[a] && !b_wr_hit(a);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin m_reg[r] = '0; m_pend[r] = 0; end
    for (int r = 0; r < BNR; r++) begin bm_reg[r] = '0; bm_pend[r] = 0; end
  endtask

  task automatic model_edge();
    for (int r = 1; r < NR; r++) begin
      if (rsv_en && int'(rsv_addr) == r) m_pend[r] = 1;
      else if (flush || s_wr_hit(r))     m_pend[r] = 0;
    end
    for (int r = 1; r < BNR; r++) begin
      if (b_rsv_en && int'(b_rsv_addr) == r) bm_pend[r] = 1;
      else if (b_flush || b_wr_hit(r))       bm_pend[r] = 0;
    end
    for (int k = 0; k < NW; k++)
      if (wr_en[k] && wr_addr[k*AW +: AW] != 0) m_reg[wr_addr[k*AW +: AW]] = wr_data[k*DW +: DW];
    for (int k = 0; k < BNW; k++)
      if (b_wr_en[k] && b_wr_addr[k*BAW +: BAW] != 0) bm_reg[b_wr_addr[k*BAW +: BAW]] = b_wr_data[k*BDW +: BDW];
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic idle();
    rs1_addr = '0; rs2_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 0; rsv_addr = '0; flush = 0;
    b_rs1_addr = '0; b_rs2_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_rsv_en = 0; b_rsv_addr = '0; b_flush = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    wr_en = 2'b01; wr_addr = {3'd0, 3'd3}; wr_data = {19'h0, 19'h7FFFF};
    rs1_addr = 3'd3; rsv_en = 1; rsv_addr = 3'd5; rs2_addr = 3'd5;
    #1;
    n_cmp++; if (d_rs1_data !== 19'h0) begin n_err++; $display("FAIL por_rs1_data: got %h exp 0", d_rs1_data); end
    n_cmp++; if (d_rs2_busy !== 1'b0) begin n_err++; $display("FAIL por_rs2_busy: got %b exp 0", d_rs2_busy); end
    #5 rst_n = 1;
    tick();
    idle(); rs1_addr = 3'd3; rs2_addr = 3'd5; #2;
    n_cmp++; if (d_rs1_data !== 19'h7FFFF) begin n_err++; $display("FAIL pre_rst_data: got %h exp 7ffff", d_rs1_data); end
    n_cmp++; if (n_rs2_busy !== 1'b1) begin n_err++; $display("FAIL pre_rst_busy: got %b exp 1", n_rs2_busy); end
    rst_n = 0; #1;
    model_reset();
    n_cmp++; if (d_rs1_data !== 19'h0 || n_rs1_data !== 19'h0) begin n_err++; $display("FAIL mid_rst_data: got %h/%h exp 0", d_rs1_data, n_rs1_data); end
    n_cmp++; if (d_rs2_busy !== 1'b0 || n_rs2_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b/%b exp 0", d_rs2_busy, n_rs2_busy); end
    #4 rst_n = 1;
    tick(); #2;
    n_cmp++; if (d_rs1_data !== 19'h0 || n_rs1_data !== 19'h0) begin n_err++; $display("FAIL post_rst_data: got %h/%h exp 0", d_rs1_data, n_rs1_data); end
    n_cmp++; if (d_rs2_busy !== 1'b0 || n_rs2_busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy: got %b/%b exp 0", d_rs2_busy, n_rs2_busy); end
  endtask

  task automatic test_collision();
    idle(); wr_en = 2'b11; wr_addr = {3'd4, 3'd4}; wr_data = {19'h00022, 19'h00011}; rs1_addr = 3'd4; #2;
    n_cmp++; if (d_rs1_data !== 19'h00022) begin n_err++; $display("FAIL coll_bypass: got %h exp 00022", d_rs1_data); end
    n_cmp++; if (n_rs1_data !== 19'h0) begin n_err++; $display("FAIL coll_nobypass_old: got %h exp 0", n_rs1_data); end
    tick();
    idle(); rs1_addr = 3'd4; #2;
    n_cmp++; if (d_rs1_data !== 19'h00022 || n_rs1_data !== 19'h00022) begin n_err++; $display("FAIL coll_stored: got %h/%h exp 00022", d_rs1_data, n_rs1_data); end
  endtask

  task automatic test_reg0();
    idle(); wr_en = 2'b10; wr_addr = {3'd0, 3'd0}; wr_data = {19'h12345, 19'h0};
    rsv_en = 1; rsv_addr = 3'd0; rs1_addr = 3'd0; #2;
    n_cmp++; if (d_rs1_data !== 19'h0 || d_rs1_busy !== 1'b0) begin n_err++; $display("FAIL r0_same: got %h/%b exp 0/0", d_rs1_data, d_rs1_busy); end
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); rs1_addr = 3'd0; #2;
      n_cmp++; if (d_rs1_data !== 19'h0 || n_rs1_data !== 19'h0) begin n_err++; $display("FAIL r0_data c%0d: got %h/%h exp 0", i, d_rs1_data, n_rs1_data); end
      n_cmp++; if (d_rs1_busy !== 1'b0 || n_rs1_busy !== 1'b0) begin n_err++; $display("FAIL r0_busy c%0d: got %b/%b exp 0", i, d_rs1_busy, n_rs1_busy); end
      tick();
    end
  endtask

  task automatic test_lifecycle();
    idle(); rsv_en = 1; rsv_addr = 3'd6; rs1_addr = 3'd6;
    tick();
    for (int c = 1; c <= 2; c++) begin
      idle(); rs1_addr = 3'd6; #2;
      n_cmp++; if (d_rs1_busy !== 1'b1 || n_rs1_busy !== 1'b1) begin n_err++; $display("FAIL life_busy c%0d: got %b/%b exp 1", c, d_rs1_busy, n_rs1_busy); end
      tick();
    end
    idle(); rs1_addr = 3'd6; wr_en = 2'b01; wr_addr = {3'd0, 3'd6}; wr_data = {19'h0, 19'h0ABCD}; #2;
    n_cmp++; if (d_rs1_busy !== 1'b0 || d_rs1_data !== 19'h0ABCD) begin n_err++; $display("FAIL life_c3_byp: got %b/%h exp 0/0abcd", d_rs1_busy, d_rs1_data); end
    n_cmp++; if (n_rs1_busy !== 1'b1 || n_rs1_data !== 19'h0) begin n_err++; $display("FAIL life_c3_nobyp: got %b/%h exp 1/0", n_rs1_busy, n_rs1_data); end
    tick();
    idle(); rs1_addr = 3'd6; #2;
    n_cmp++; if (n_rs1_busy !== 1'b0 || n_rs1_data !== 19'h0ABCD) begin n_err++; $display("FAIL life_c4_nobyp: got %b/%h exp 0/0abcd", n_rs1_busy, n_rs1_data); end
    n_cmp++; if (d_rs1_busy !== 1'b0 || d_rs1_data !== 19'h0ABCD) begin n_err++; $display("FAIL life_c4_byp: got %b/%h exp 0/0abcd", d_rs1_busy, d_rs1_data); end
  endtask

  task automatic test_simultaneous();
    idle(); rsv_en = 1; rsv_addr = 3'd2; tick();
    idle(); rsv_en = 1; rsv_addr = 3'd7; tick();
    idle(); rsv_en = 1; rsv_addr = 3'd2; flush = 1;
    wr_en = 2'b01; wr_addr = {3'd0, 3'd2}; wr_data = {19'h0, 19'h00055};
    tick();
    idle(); rs1_addr = 3'd2; rs2_addr = 3'd7; #2;
    n_cmp++; if (d_rs1_data !== 19'h00055 || n_rs1_data !== 19'h00055) begin n_err++; $display("FAIL simul_data: got %h/%h exp 00055", d_rs1_data, n_rs1_data); end
    n_cmp++; if (d_rs1_busy !== 1'b1 || n_rs1_busy !== 1'b1) begin n_err++; $display("FAIL simul_pend: got %b/%b exp 1", d_rs1_busy, n_rs1_busy); end
    n_cmp++; if (d_rs2_busy !== 1'b0 || n_rs2_busy !== 1'b0) begin n_err++; $display("FAIL simul_flush: got %b/%b exp 0", d_rs2_busy, n_rs2_busy); end
  endtask

  task automatic test_sweep();
    idle(); b_wr_en = 3'b100; b_wr_addr = {4'd15, 4'd0, 4'd0}; b_wr_data = {32'hDEADBEEF, 64'h0}; b_rs2_addr = 4'd15; #2;
    n_cmp++; if (b_rs2_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL sweep_byp: got %h exp deadbeef", b_rs2_data); end
    tick();
    idle(); b_rs2_addr = 4'd15; #2;
    n_cmp++; if (b_rs2_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL sweep_stored: got %h exp deadbeef", b_rs2_data); end
    b_wr_en = 3'b111; b_wr_addr = {4'd9, 4'd9, 4'd9}; b_wr_data = {32'h3, 32'h2, 32'h1}; b_rs1_addr = 4'd9;
    tick();
    idle(); b_rs1_addr = 4'd9; #2;
    n_cmp++; if (b_rs1_data !== 32'h3) begin n_err++; $display("FAIL sweep_coll3: got %h exp 3", b_rs1_data); end
  endtask

  task automatic test_random();
    logic [DW-1:0]  ed;
    logic [BDW-1:0] eb;
    bit             ebz;
    for (int i = 0; i < 10000; i++) begin
      wr_en = NW'($urandom); wr_addr = (NW*AW)'($urandom); wr_data = {DW'($urandom), DW'($urandom)};
      rsv_en = ($urandom_range(0, 2) == 0); rsv_addr = AW'($urandom); flush = ($urandom_range(0, 15) == 0);
      rs1_addr = AW'($urandom); rs2_addr = AW'($urandom);
      b_wr_en = BNW'($urandom); b_wr_addr = (BNW*BAW)'($urandom); b_wr_data = {$urandom, $urandom, $urandom};
      b_rsv_en = ($urandom_range(0, 2) == 0); b_rsv_addr = BAW'($urandom); b_flush = ($urandom_range(0, 15) == 0);
      b_rs1_addr = BAW'($urandom); b_rs2_addr = BAW'($urandom);
      #2;
      ed = s_exp_data(int'(rs1_addr), 1);  n_cmp++; if (d_rs1_data !== ed) begin n_err++; $display("FAIL rnd_d_rs1_data i%0d: got %h exp %h", i, d_rs1_data, ed); end
      ed = s_exp_data(int'(rs2_addr), 1);  n_cmp++; if (d_rs2_data !== ed) begin n_err++; $display("FAIL rnd_d_rs2_data i%0d: got %h exp %h", i, d_rs2_data, ed); end
      ed = s_exp_data(int'(rs1_addr), 0);  n_cmp++; if (n_rs1_data !== ed) begin n_err++; $display("FAIL rnd_n_rs1_data i%0d: got %h exp %h", i, n_rs1_data, ed); end
      ed = s_exp_data(int'(rs2_addr), 0);  n_cmp++; if (n_rs2_data !== ed) begin n_err++; $display("FAIL rnd_n_rs2_data i%0d: got %h exp %h", i, n_rs2_data, ed); end
      ebz = s_exp_busy(int'(rs1_addr), 1); n_cmp++; if (d_rs1_busy !== ebz) begin n_err++; $display("FAIL rnd_d_rs1_busy i%0d: got %b exp %b", i, d_rs1_busy, ebz); end
      ebz = s_exp_busy(int'(rs2_addr), 1); n_cmp++; if (d_rs2_busy !== ebz) begin n_err++; $display("FAIL rnd_d_rs2_busy i%0d: got %b exp %b", i, d_rs2_busy, ebz); end
      ebz = s_exp_busy(int'(rs1_addr), 0); n_cmp++; if (n_rs1_busy !== ebz) begin n_err++; $display("FAIL rnd_n_rs1_busy i%0d: got %b exp %b", i, n_rs1_busy, ebz); end
      ebz = s_exp_busy(int'(rs2_addr), 0); n_cmp++; if (n_rs2_busy !== ebz) begin n_err++; $display("FAIL rnd_n_rs2_busy i%0d: got %b exp %b", i, n_rs2_busy, ebz); end
      eb = b_exp_data(int'(b_rs1_addr));   n_cmp++; if (b_rs1_data !== eb) begin n_err++; $display("FAIL rnd_b_rs1_data i%0d: got %h exp %h", i, b_rs1_data, eb); end
      eb = b_exp_data(int'(b_rs2_addr));   n_cmp++; if (b_rs2_data !== eb) begin n_err++; $display("FAIL rnd_b_rs2_data i%0d: got %h exp %h", i, b_rs2_data, eb); end
      ebz = b_exp_busy(int'(b_rs1_addr));  n_cmp++; if (b_rs1_busy !== ebz) begin n_err++; $display("FAIL rnd_b_rs1_busy i%0d: got %b exp %b", i, b_rs1_busy, ebz); end
      ebz = b_exp_busy(int'(b_rs2_addr));  n_cmp++; if (b_rs2_busy !== ebz) begin n_err++; $display("FAIL rnd_b_rs2_busy i%0d: got %b exp %b", i, b_rs2_busy, ebz); end
      tick();
    end
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_collision();
    test_reg0();
    test_lifecycle();
    test_simultaneous();
    test_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the core's 8x19-bit register file.
- Adds configurable depth and width, N write ports with fixed priority, and optional write-to-read bypass.
- Adds asynchronous clear and a per-register pending scoreboard so the issue stage can stall on in-flight producers.
- Sits between decode/issue (reads, reservations) and writeback (writes) in the pipelined core.

Parameters:
- DATA_W, 19, register width in bits.
- NUM_REGS, 8, number of architectural registers; power of two, >= 2.
- ADDR_W, 3, address width; must equal clog2(NUM_REGS).
- NUM_WR, 2, number of write ports, 1..4.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_addr  in  ADDR_W  read port 1 address.
- rs2_addr  in  ADDR_W  read port 2 address.
- rs1_data  out  DATA_W  read port 1 data (combinational).
- rs2_data  out  DATA_W  read port 2 data (combinational).
- rs1_busy  out  1  register at rs1_addr has an outstanding producer.
- rs2_busy  out  1  register at rs2_addr has an outstanding producer.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- wr_data  in  NUM_WR*DATA_W  packed write data; port k occupies bits [k*DATA_W +: DATA_W].
- rsv_en  in  1  reserve destination: mark rsv_addr pending.
- rsv_addr  in  ADDR_W  destination being reserved.
- flush  in  1  clear all pending bits (pipeline squash).

Behaviour:
- Reset (rst_n=0, asynchronous): all registers = 0, all pending bits = 0. While in reset: rs*_data = 0 and rs*_busy = 0 regardless of inputs. Deassertion takes effect at the next rising edge.
- Register 0:
  - Hardwired zero; writes to address 0 are dropped.
  - Reads of address 0 return 0, including when bypassing.
  - Never pending; rsv_addr=0 is ignored.
- Write, at rising edge, for each port k with wr_en[k]=1 and wr_addr_k != 0: reg[wr_addr_k] <= wr_data_k.
- Write collision: several enabled ports targeting the same address are resolved by the highest port index.
- Read latency: 0 cycles (combinational).
  - BYPASS=1: if any enabled port targets a nonzero rs address this cycle, output the winning (highest-index) port's wr_data; otherwise the stored value.
  - BYPASS=0: output the stored value; new data is visible from the cycle after the edge.
- Scoreboard, one pending bit per register. Next-state priority, per register r, highest first:
  1. rst_n=0 -> 0.
  2. rsv_en=1 and rsv_addr=r (r != 0) -> 1. A new producer overrides a same-cycle writeback or flush.
  3. flush=1 -> 0.
  4. Any enabled write to r -> 0.
  5. Otherwise hold.
- Busy outputs:
  - BYPASS=1: rsN_busy = pending[rsN_addr] AND NOT (an enabled write to rsN_addr this cycle). The forwarded value is valid.
  - BYPASS=0: rsN_busy = pending[rsN_addr].
  - Busy is never asserted for address 0.
- The block has no error outputs. Double reservation of an already-pending register simply keeps it pending.
- Out-of-range addresses cannot occur because NUM_REGS = 2^ADDR_W.

Decomposition:
- Shared package regfile_pkg:
  - constants RF_DATA_W=19, RF_NUM_REGS=8, RF_ADDR_W=3;
  - localparam function for the clog2 check;
  - zero-register address constant.
- One natural sub-module: regfile_scoreboard. It holds the pending bit vector, rsv/flush/write-clear priority logic and busy lookup. The top level owns the storage array, write-priority mux and bypass muxes.

Test Plan:
- Reset mid-operation: write 0x7FFFF to r3, pend r5, pulse rst_n low for a half cycle -> rs1(r3)=0 and rs2_busy(r5)=0 immediately, and both stay cleared after release.
- Dual-port collision, NUM_WR=2: wr_en=2'b11, both ports address r4, port0 data 0x00011, port1 data 0x00022 -> r4=0x00022 after the edge. With BYPASS=1, rs1(r4)=0x00022 in the same cycle.
- Register 0: write 0x12345 to r0 and reserve r0 -> rs1(r0)=0 and rs1_busy=0 on every following cycle.
- Scoreboard lifecycle: rsv r6 at cycle 0 -> rs1_busy(r6)=1 from cycle 1. Write r6=0x0ABCD at cycle 3:
  - BYPASS=1: busy=0 and data=0x0ABCD during cycle 3.
  - BYPASS=0: busy=1 and old data in cycle 3, busy=0 and 0x0ABCD in cycle 4.
- Simultaneous events: r2 pending; same cycle rsv r2, write r2=0x00055 and flush=1 -> r2 holds 0x00055 and stays pending; every other pending register is cleared.
- Parameter sweep: DATA_W=32, NUM_REGS=16, ADDR_W=4, NUM_WR=3. Write r15=0xDEADBEEF via port 2 -> rs2(r15)=0xDEADBEEF; randomised writes/reads checked against a reference model over 10k cycles.
